// File: rtl/tristate_bus_reader.sv
// Read master for a shared tri-state bus: address phase, turnaround, then wait
// for the remote ack (or time out) and capture the returned data.
module tristate_bus_reader #(
    parameter int WIDTH   = 8,
    parameter int TURN    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] addr,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             ack,
    output logic             cmd,
    output logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_TURN = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [3:0]       turn_cnt_q, turn_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             cmd_q, cmd_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    // Bus is driven straight from the state register so it releases on reset at once.
    assign bus      = (state_q == ST_ADDR) ? addr_q : {WIDTH{1'bz}};
    assign cmd      = cmd_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign data_out = data_out_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= {WIDTH{1'b0}};
            turn_cnt_q <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            cmd_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            turn_cnt_q <= turn_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            cmd_q      <= cmd_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    // Next-state logic; ack wins over timeout in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ADDR;
                else       state_d = ST_IDLE;
            end
            ST_ADDR: state_d = ST_TURN;
            ST_TURN: begin
                if (turn_cnt_q == 4'd0) state_d = ST_WAIT;
                else                    state_d = ST_TURN;
            end
            ST_WAIT: begin
                if (ack)                         state_d = ST_IDLE;
                else if (tmo_cnt_q == TMO_LAST)  state_d = ST_IDLE;
                else                             state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of counters, captured address and the registered outputs.
    always_comb begin
        addr_d     = addr_q;
        turn_cnt_d = 4'd0;
        tmo_cnt_d  = 8'd0;
        if (state_q == ST_IDLE && start) addr_d = addr;
        else                             addr_d = addr_q;
        case (state_q)
            ST_ADDR: turn_cnt_d = TURN_LOAD;
            ST_TURN: begin
                if (turn_cnt_q != 4'd0) turn_cnt_d = turn_cnt_q - 4'd1;
                else                    turn_cnt_d = 4'd0;
            end
            ST_WAIT: begin
                if (state_d == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 8'd1;
                else                    tmo_cnt_d = 8'd0;
            end
            default: begin
                turn_cnt_d = 4'd0;
                tmo_cnt_d  = 8'd0;
            end
        endcase
        cmd_d   = (state_d == ST_ADDR);
        rd_en_d = (state_d == ST_TURN) || (state_d == ST_WAIT);
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_q == ST_WAIT) && ack;
        err_d   = (state_q == ST_WAIT) && !ack && (tmo_cnt_q == TMO_LAST);
        if (valid_d) data_out_d = bus;
        else         data_out_d = data_out_q;
    end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Bench for tristate_bus_reader: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_tristate_bus_reader;

    localparam int WIDTH   = 8;
    localparam int TURN    = 2;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst, start, ack;
    logic [WIDTH-1:0] addr, drv_val;
    wire  [WIDTH-1:0] bus;
    logic             cmd, rd_en, valid, err, busy;
    logic [WIDTH-1:0] data_out;

    int n_vec = 0;
    int n_bad = 0;

    // Model: a transaction is "active" with an age in cycles since acceptance.
    // age 1 = address phase, 2..TURN+1 = turnaround, beyond that = waiting.
    logic             m_active;
    int               m_age;
    logic [WIDTH-1:0] m_addr, m_data;
    logic             m_valid, m_err;
    logic             drv_en;

    // The remote side drives the bus whenever the reader should not be.
    assign drv_en = !(m_active && m_age == 1);
    assign bus    = drv_en ? drv_val : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    tristate_bus_reader #(.WIDTH(WIDTH), .TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .bus(bus), .ack(ack),
        .cmd(cmd), .rd_en(rd_en), .data_out(data_out), .valid(valid),
        .err(err), .busy(busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_addr   <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_age    <= 1;
                    m_addr   <= addr;
                end
            end else if (m_age >= TURN + 2) begin
                if (ack) begin
                    m_data   <= drv_val;
                    m_valid  <= 1'b1;
                    m_active <= 1'b0;
                end else if (m_age - (TURN + 2) == TIMEOUT - 1) begin
                    m_err    <= 1'b1;
                    m_active <= 1'b0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("busy",     busy,     m_active);
        chk("cmd",      cmd,      m_active && m_age == 1);
        chk("rd_en",    rd_en,    m_active && m_age >= 2);
        chk("valid",    valid,    m_valid);
        chk("err",      err,      m_err);
        chk("data_out", data_out, m_data);
        chk("bus",      bus,      (m_active && m_age == 1) ? m_addr : drv_val);
        chk("cmd_and_rd_en", cmd & rd_en, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cmp_model();
        @(negedge clk);
    endtask

    task automatic chk_reset_now();
        chk("rst_cmd",   cmd,      1'b0);
        chk("rst_rd_en", rd_en,    1'b0);
        chk("rst_valid", valid,    1'b0);
        chk("rst_err",   err,      1'b0);
        chk("rst_busy",  busy,     1'b0);
        chk("rst_data",  data_out, 8'h00);
        chk("rst_bus",   bus,      drv_val);
    endtask

    task automatic go_to_wait(input logic [WIDTH-1:0] a);
        start = 1'b1;
        addr  = a;
        cyc();
        start = 1'b0;
        repeat (TURN + 1) cyc();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; addr = 8'h00; drv_val = 8'h11;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_now();
        @(negedge clk);
        rst = 1'b0;

        // Immediate ack: address phase, two turnaround cycles, valid 4 edges after start.
        start = 1'b1; addr = 8'hA5;
        cyc();
        start = 1'b0;
        chk("a_cmd",   cmd,   1'b1);
        chk("a_bus",   bus,   8'hA5);
        chk("a_rd_en", rd_en, 1'b0);
        drv_val = 8'h22;
        cyc();
        chk("t1_cmd",   cmd,   1'b0);
        chk("t1_rd_en", rd_en, 1'b1);
        chk("t1_bus",   bus,   8'h22);
        cyc();
        chk("t2_rd_en", rd_en, 1'b1);
        chk("t2_bus",   bus,   8'h22);
        cyc();
        ack = 1'b1; drv_val = 8'h3C;
        cyc();
        ack = 1'b0;
        chk("ok_valid", valid,    1'b1);
        chk("ok_err",   err,      1'b0);
        chk("ok_data",  data_out, 8'h3C);
        chk("ok_busy",  busy,     1'b0);
        cyc();
        chk("ok_valid_drop", valid, 1'b0);

        // No ack: err exactly TIMEOUT cycles after WAIT entry, data retained.
        go_to_wait(8'hA5);
        repeat (TIMEOUT - 1) begin
            cyc();
            chk("to_err_early", err,  1'b0);
            chk("to_busy",      busy, 1'b1);
        end
        cyc();
        chk("to_err",   err,      1'b1);
        chk("to_valid", valid,    1'b0);
        chk("to_data",  data_out, 8'h3C);
        cyc();
        chk("to_err_drop", err, 1'b0);

        // Ack on the last timeout cycle wins.
        go_to_wait(8'hA5);
        repeat (TIMEOUT - 1) cyc();
        ack = 1'b1; drv_val = 8'h5A;
        cyc();
        ack = 1'b0;
        chk("late_valid", valid,    1'b1);
        chk("late_err",   err,      1'b0);
        chk("late_data",  data_out, 8'h5A);

        // Start during turnaround is dropped.
        start = 1'b1; addr = 8'hA5;
        cyc();
        start = 1'b0;
        chk("ign_addr_bus", bus, 8'hA5);
        cyc();
        start = 1'b1; addr = 8'hFF;
        cyc();
        start = 1'b0;
        cyc();
        ack = 1'b1; drv_val = 8'h77;
        cyc();
        ack = 1'b0;
        chk("ign_valid", valid,    1'b1);
        chk("ign_data",  data_out, 8'h77);
        repeat (4) begin
            cyc();
            chk("ign_busy", busy, 1'b0);
            chk("ign_cmd",  cmd,  1'b0);
        end

        // Asynchronous reset in WAIT, then a normal read.
        go_to_wait(8'hA5);
        cyc();
        drv_val = 8'h99;
        rst = 1'b1;
        #1;
        chk_reset_now();
        #1;
        rst = 1'b0;
        cyc();
        chk("prst_valid", valid, 1'b0);
        chk("prst_err",   err,   1'b0);
        go_to_wait(8'h42);
        ack = 1'b1; drv_val = 8'h3C;
        cyc();
        ack = 1'b0;
        chk("prst_ok_valid", valid,    1'b1);
        chk("prst_ok_data",  data_out, 8'h3C);

        // Random traffic against the model.
        repeat (3000) begin
            start   = ($urandom_range(3, 0) == 0);
            addr    = 8'($urandom);
            ack     = ($urandom_range(15, 0) == 0);
            drv_val = 8'($urandom);
            if ($urandom_range(299, 0) == 0) begin
                rst = 1'b1;
                #1;
                chk_reset_now();
                #1;
                rst = 1'b0;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tristate_bus_reader.md
TRISTATE_BUS_READER -- requirements
Module: tristate_bus_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, shared bus and data width in bits.
REQ-002 SHALL have parameter TURN, default 2, bus turnaround cycles (range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ack wait cycles (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read.
REQ-007 SHALL have port addr  input  WIDTH  read address, captured on accepted start.
REQ-008 SHALL have port bus  inout  WIDTH  shared tri-state bus, driven by this block only in ADDR.
REQ-009 SHALL have port ack  input  1  remote device is driving valid data on bus.
REQ-010 SHALL have port cmd  output  1  address phase strobe to remote device.
REQ-011 SHALL have port rd_en  output  1  enable for remote device's tri-state buffer.
REQ-012 SHALL have port data_out  output  WIDTH  last successfully read data.
REQ-013 SHALL have port valid  output  1  one-cycle pulse, data_out updated.
REQ-014 SHALL have port err  output  1  one-cycle pulse, read timed out.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, TURN, WAIT.
REQ-017 IDLE: start=1 SHALL capture addr into an internal register and go to ADDR next cycle; start=0 stays IDLE.
REQ-018 ADDR: bus SHALL be driven with captured address, cmd=1, rd_en=0; lasts exactly 1 cycle, then TURN.
REQ-019 TURN: bus SHALL be high-Z, cmd=0, rd_en=1; lasts exactly TURN cycles (counter loaded on ADDR exit), then WAIT.
REQ-020 WAIT: bus SHALL be high-Z, rd_en=1; timeout counter starts at 0 on entry, increments each cycle without ack.
REQ-021 WAIT with ack=1 SHALL load data_out with bus value on that edge, pulse valid for 1 cycle, return to IDLE.
REQ-022 WAIT with ack=0 on the cycle counter equals TIMEOUT-1 SHALL pulse err for 1 cycle, leave data_out unchanged, return to IDLE.
REQ-023 ack=1 on the timeout cycle SHALL take priority: valid pulses, err stays 0.
REQ-024 ack SHALL be ignored in IDLE, ADDR and TURN.
REQ-025 start while busy=1 SHALL be ignored, not queued; captured address SHALL not change.
REQ-026 start in the same cycle valid or err pulses SHALL be accepted (FSM already in IDLE on that edge's next cycle only; i.e. start accepted when state is IDLE).
REQ-027 Latency start-to-valid SHALL be 1 (ADDR) + TURN + 1 + N cycles, N = ack wait cycles in WAIT; minimum 4 with TURN=2 and ack immediate.
REQ-028 bus SHALL never be driven by this block when rd_en=1; cmd and rd_en SHALL never be high together.
REQ-029 All outputs SHALL be registered; bus output enable SHALL derive directly from state register.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, bus high-Z, cmd=0, rd_en=0, valid=0, err=0, busy=0, data_out=0, counters=0.
REQ-031 rst asserted mid-transaction SHALL abort it with no valid or err pulse; first start after rst release SHALL be accepted normally.

Verification
REQ-032 TURN=2: start, addr=8'hA5; remote drives 8'h3C with ack on first WAIT cycle -> bus=A5 with cmd=1 for 1 cycle, 2 high-Z cycles, valid pulse with data_out=8'h3C 4 cycles after start.
REQ-033 Same start, ack never asserted -> err pulse exactly TIMEOUT cycles after WAIT entry, data_out retains 8'h3C, valid=0.
REQ-034 ack first rises on last timeout cycle with bus=8'h5A -> valid=1, err=0, data_out=8'h5A.
REQ-035 Second start with addr=8'hFF during TURN -> ignored; ADDR phase of current read showed A5; no second transaction follows.
REQ-036 rst pulsed in WAIT -> bus high-Z and all outputs 0 immediately, before the next clk edge; no valid/err; next start completes normally.
REQ-037 Every cycle of all scenarios -> checker confirms cmd and rd_en never both 1 and bus high-Z outside ADDR.
